binpool1_seq: RTL

- Binary 2x2 max-pool stage directly downstream of the first binarized convolution accumulator.
- Accepts one full 18-channel 24x24 sign-bit feature frame through a valid/ready handshake and stores it.
- Emits the pooled 12x12 result one output row at a time, across all channels, over a valid/ready stream toward layer 2.
- Bit value 1 means +1 and 0 means -1, so the binary max of a window is the OR of its four bits.

---
 rtl/binpool_pkg.sv | 19 +
 rtl/pool2x2_row.sv | 23 ++
 rtl/binpool1_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/binpool_pkg.sv
// Shared constants, FSM state type and frame indexing helper for the
// binary 2x2 max-pool stage that follows the first binarized convolution.
package binpool_pkg;

    localparam int CH = 18;
    localparam int IW = 24;
    localparam int OW = IW / 2;
    localparam int RW = $clog2(OW);
    localparam int FB = CH * IW * IW;
    localparam int RB = CH * OW;

    typedef enum logic {IDLE, EMIT} pool_state_t;

    // Flat bit position of channel k, row r, column c inside a stored frame.
    function automatic int in_idx(input int k, input int r, input int c);
        return k * IW * IW + r * IW + c;
    endfunction

endpackage

// File: rtl/pool2x2_row.sv
// Purely combinational 2x2 binary max-pool of one output row across all channels.
// A 1 bit means +1, so the max of a window is the OR of its four bits.
module pool2x2_row
    import binpool_pkg::*;
(
    input  logic [0:FB-1]   i_frame,
    input  logic [RW-1:0]   i_row,
    output logic [0:RB-1]   o_row
);

    always_comb begin
        o_row = '0;
        for (int k = 0; k < CH; k++) begin
            for (int j = 0; j < OW; j++) begin
                o_row[k*OW + j] = i_frame[in_idx(k, 2*int'(i_row),     2*j)]
                                | i_frame[in_idx(k, 2*int'(i_row),     2*j + 1)]
                                | i_frame[in_idx(k, 2*int'(i_row) + 1, 2*j)]
                                | i_frame[in_idx(k, 2*int'(i_row) + 1, 2*j + 1)];
            end
        end
    end

endmodule

// File: rtl/binpool1_seq.sv
// Frame-in / row-out wrapper: stores one full sign-bit frame, then streams
// the pooled rows toward layer 2 under valid/ready flow control.
module binpool1_seq
    import binpool_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:FB-1]   in_frame,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:RB-1]   out_row,
    output logic [RW-1:0]   out_row_idx,
    output logic            out_last
);

    localparam logic [RW-1:0] LAST_ROW = RW'(OW - 1);

    pool_state_t      r_state;
    pool_state_t      w_next_state;
    logic [RW-1:0]    r_row_cnt;
    logic [RW-1:0]    w_next_row_cnt;
    logic [0:FB-1]    r_frame;
    logic             w_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_row_cnt <= '0;
            r_frame   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_row_cnt <= w_next_row_cnt;
            if (w_load) begin
                r_frame <= in_frame;
            end
        end
    end

    // Row counter only advances on a completed output handshake, so all
    // outputs stay frozen while the downstream stalls.
    always_comb begin
        w_next_state   = r_state;
        w_next_row_cnt = r_row_cnt;
        w_load         = 1'b0;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load         = 1'b1;
                    w_next_row_cnt = '0;
                    w_next_state   = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_row_cnt == LAST_ROW) begin
                        w_next_row_cnt = '0;
                        w_next_state   = IDLE;
                    end else begin
                        w_next_row_cnt = r_row_cnt + RW'(1);
                    end
                end
            end
            default: begin
                w_next_state   = IDLE;
                w_next_row_cnt = '0;
            end
        endcase
    end

    assign out_row_idx = r_row_cnt;
    assign out_last    = out_valid && (r_row_cnt == LAST_ROW);

    pool2x2_row u_pool (
        .i_frame (r_frame),
        .i_row   (r_row_cnt),
        .o_row   (out_row)
    );

endmodule
